// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S frame constants, sample types and slot-position helpers
package i2s_pkg;
    localparam int FRAME_BITS = 64;
    localparam int SLOT_BITS  = 32;
    localparam int MAX_WIDTH  = SLOT_BITS - 1;

    typedef logic [MAX_WIDTH-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } sample_pair_t;

    function automatic logic [4:0] slot_pos(logic [5:0] b);
        return 5'(b % 6'(SLOT_BITS));
    endfunction

    // slot position 0 is the I2S one-bit delay; data occupies positions 1..width
    function automatic logic in_sample(logic [4:0] p, int width);
        return p != 5'd0 && int'(p) <= width;
    endfunction
endpackage

// File: rtl/i2s_if.sv
// i2s_if: I2S serial pins plus parallel sample ports of the driver
interface i2s_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  mclk_o;
    logic                  bclk_o;
    logic                  lrclk_o;
    logic                  sdata_o;
    logic                  sdata_i;
    logic [DATA_WIDTH-1:0] tx_left;
    logic [DATA_WIDTH-1:0] tx_right;
    logic                  sample_tick;
    logic [DATA_WIDTH-1:0] rx_left;
    logic [DATA_WIDTH-1:0] rx_right;
    logic                  rx_valid;

    modport master (
        output mclk_o, bclk_o, lrclk_o, sdata_o, sample_tick, rx_left, rx_right, rx_valid,
        input  sdata_i, tx_left, tx_right
    );

    modport slave (
        input  mclk_o, bclk_o, lrclk_o, sdata_o, sample_tick, rx_left, rx_right, rx_valid,
        output sdata_i, tx_left, tx_right
    );
endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: free-running mclk/bclk/lrclk generation with bclk edge strobes
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int BCLK_HALF = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic       mclk,
    output logic       bclk,
    output logic       lrclk,
    output logic       fall,
    output logic       rise,
    output logic       wrap,
    output logic [5:0] bit_cnt,
    output logic [5:0] bit_nxt
);
    localparam int DIV_W = $clog2(2 * BCLK_HALF);
    localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(2 * BCLK_HALF - 1);
    localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(BCLK_HALF - 1);

    logic [DIV_W-1:0] div_cnt, div_nxt;

    // strobes flag the clk edge on which bclk is about to fall or rise
    always_comb begin
        fall    = div_cnt == DIV_TOP;
        rise    = div_cnt == RISE_AT;
        div_nxt = fall ? '0 : div_cnt + 1'b1;
        bit_nxt = fall ? bit_cnt + 6'd1 : bit_cnt;
        wrap    = fall && bit_cnt == 6'(FRAME_BITS - 1);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            mclk    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= div_nxt >= DIV_W'(BCLK_HALF);
            mclk    <= ~mclk;
        end

    assign lrclk = bit_cnt[5];
endmodule

// File: rtl/i2s_driver.sv
// i2s_driver: I2S master serialising tx sample pairs and deserialising rx pairs per 64-bit frame
module i2s_driver
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_HALF  = 4
) (
    input logic   clk,
    input logic   rst,
    i2s_if.master bus
);
    logic                  mclk, bclk, lrclk;
    logic                  fall, rise, wrap;
    logic [5:0]            bit_cnt, bit_nxt;
    logic                  tx_on, rx_on, tx_bit;
    logic                  sdata, tick;
    logic [DATA_WIDTH-1:0] rx_left, rx_right;
    sample_pair_t          sh, cap;

    i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
        .clk     (clk),
        .rst     (rst),
        .mclk    (mclk),
        .bclk    (bclk),
        .lrclk   (lrclk),
        .fall    (fall),
        .rise    (rise),
        .wrap    (wrap),
        .bit_cnt (bit_cnt),
        .bit_nxt (bit_nxt)
    );

    // tx looks at the bit about to start; rx samples the bit currently on the line
    always_comb begin
        tx_on  = in_sample(slot_pos(bit_nxt), DATA_WIDTH);
        rx_on  = rise && in_sample(slot_pos(bit_cnt), DATA_WIDTH);
        tx_bit = tx_on && (bit_nxt[5] ? sh.right[DATA_WIDTH-1] : sh.left[DATA_WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sh       <= '0;
            cap      <= '0;
            sdata    <= 1'b0;
            tick     <= 1'b0;
            rx_left  <= '0;
            rx_right <= '0;
        end else begin
            tick <= wrap;
            if (fall)
                sdata <= tx_bit;
            if (wrap) begin
                sh.left  <= sample_t'(bus.tx_left);
                sh.right <= sample_t'(bus.tx_right);
                rx_left  <= cap.left[DATA_WIDTH-1:0];
                rx_right <= cap.right[DATA_WIDTH-1:0];
            end else if (fall && tx_on) begin
                if (bit_nxt[5])
                    sh.right <= sh.right << 1;
                else
                    sh.left <= sh.left << 1;
            end
            if (rx_on && bit_cnt[5])
                cap.right <= (cap.right << 1) | sample_t'(bus.sdata_i);
            if (rx_on && !bit_cnt[5])
                cap.left <= (cap.left << 1) | sample_t'(bus.sdata_i);
        end

    assign bus.mclk_o      = mclk;
    assign bus.bclk_o      = bclk;
    assign bus.lrclk_o     = lrclk;
    assign bus.sdata_o     = sdata;
    assign bus.sample_tick = tick;
    assign bus.rx_valid    = tick;
    assign bus.rx_left     = rx_left;
    assign bus.rx_right    = rx_right;
endmodule

// File: tb/tb_i2s_driver.sv
// tb_i2s_driver: randomized self-checking bench against a frame-level I2S reference model
module tb_i2s_driver;
    localparam int W  = 16;
    localparam int H  = 4;
    localparam int FR = 128 * H;

    logic clk = 1'b0;
    logic rst;
    logic loop = 1'b0;
    logic const_i = 1'b0;

    i2s_if #(.DATA_WIDTH(W)) bus ();

    i2s_driver #(.DATA_WIDTH(W), .BCLK_HALF(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.sdata_i = loop ? bus.sdata_o : const_i;

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int n;
    logic [W-1:0] cur_l, cur_r, rxe_l, rxe_r;
    logic [5:0] ev, ov;

    // a slot carries a delay bit, the sample MSB first, then zero padding
    function automatic logic slot_bit(logic [W-1:0] l, logic [W-1:0] r, int b);
        int p;
        logic [W-1:0] s;
        p = b % 32;
        s = (b < 32) ? l : r;
        return (p >= 1 && p <= W) ? s[W-p] : 1'b0;
    endfunction

    task automatic reset_model();
        n = 0;
        cur_l = '0;
        cur_r = '0;
        rxe_l = '0;
        rxe_r = '0;
    endtask

    // advance one clk; on frame boundaries the model latches tx and publishes the ending frame's rx
    task automatic step();
        int b;
        @(posedge clk);
        n++;
        if (n % FR == 0) begin
            rxe_l = loop ? cur_l : {W{const_i}};
            rxe_r = loop ? cur_r : {W{const_i}};
            cur_l = bus.tx_left;
            cur_r = bus.tx_right;
        end
        #1;
        b = (n / (2 * H)) % 64;
        ev = {n[0], (n % (2 * H)) >= H, b >= 32, slot_bit(cur_l, cur_r, b), n % FR == 0, n % FR == 0};
        ov = {bus.mclk_o, bus.bclk_o, bus.lrclk_o, bus.sdata_o, bus.sample_tick, bus.rx_valid};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.tx_left = W'($urandom);
        bus.tx_right = W'($urandom);
        repeat (4) @(posedge clk);
        #1;
        ov = {bus.mclk_o, bus.bclk_o, bus.lrclk_o, bus.sdata_o, bus.sample_tick, bus.rx_valid};
        compared++;
        if ({ov, bus.rx_left, bus.rx_right} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got %b %h %h want all zero", ov, bus.rx_left, bus.rx_right);
        end
        @(negedge clk);
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_clocks();
        int first_rise = -1;
        int first_tick = -1;
        int lr_hi = 0;
        for (int i = 0; i < FR; i++) begin
            step();
            compared++;
            if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                mismatched++;
                $display("FAIL clocks n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
            end
            if (bus.bclk_o && first_rise < 0) first_rise = n;
            if (bus.sample_tick && first_tick < 0) first_tick = n;
            lr_hi += int'(bus.lrclk_o);
        end
        compared++;
        if (first_rise !== 4) begin
            mismatched++;
            $display("FAIL first_bclk_rise got %0d want 4", first_rise);
        end
        compared++;
        if (first_tick !== FR) begin
            mismatched++;
            $display("FAIL first_tick got %0d want %0d", first_tick, FR);
        end
        compared++;
        if (lr_hi !== FR / 2) begin
            mismatched++;
            $display("FAIL lrclk_high_cycles got %0d want %0d", lr_hi, FR / 2);
        end
    endtask

    task automatic test_pattern();
        logic [63:0] fr = '0;
        logic [63:0] want;
        want = {1'b0, 16'hA5C3, 15'd0, 1'b0, 16'h0001, 15'd0};
        loop = 1'b0;
        const_i = 1'b0;
        bus.tx_left = 16'hA5C3;
        bus.tx_right = 16'h0001;
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < FR; i++) begin
                step();
                compared++;
                if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                    mismatched++;
                    $display("FAIL pattern n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
                end
                if (f == 1 && n % (2 * H) == H) fr = {fr[62:0], bus.sdata_o};
            end
        compared++;
        if (fr !== want) begin
            mismatched++;
            $display("FAIL pattern_frame got %h want %h", fr, want);
        end
    endtask

    task automatic test_loopback();
        loop = 1'b1;
        bus.tx_left = 16'h8000;
        bus.tx_right = 16'h7FFF;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < FR; i++) begin
                step();
                compared++;
                if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                    mismatched++;
                    $display("FAIL loopback n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
                end
            end
            if (f == 1) begin
                compared++;
                if ({bus.rx_left, bus.rx_right, bus.rx_valid} !== {16'h8000, 16'h7FFF, 1'b1}) begin
                    mismatched++;
                    $display("FAIL loopback_extremes got %h %h %b want 8000 7fff 1", bus.rx_left, bus.rx_right, bus.rx_valid);
                end
            end
            if (f >= 1) begin
                bus.tx_left = W'($urandom);
                bus.tx_right = W'($urandom);
            end
        end
    endtask

    task automatic test_const_ones();
        loop = 1'b0;
        const_i = 1'b1;
        for (int f = 0; f < 2; f++) begin
            bus.tx_left = W'($urandom);
            bus.tx_right = W'($urandom);
            for (int i = 0; i < FR; i++) begin
                step();
                compared++;
                if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                    mismatched++;
                    $display("FAIL const_ones n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
                end
            end
            compared++;
            if ({bus.rx_left, bus.rx_right, bus.rx_valid} !== {16'hFFFF, 16'hFFFF, 1'b1}) begin
                mismatched++;
                $display("FAIL const_ones_rx got %h %h %b want ffff ffff 1", bus.rx_left, bus.rx_right, bus.rx_valid);
            end
        end
        const_i = 1'b0;
    endtask

    task automatic test_tx_hold();
        loop = 1'b1;
        bus.tx_left = 16'h1234;
        bus.tx_right = W'($urandom);
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < FR; i++) begin
                step();
                compared++;
                if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                    mismatched++;
                    $display("FAIL tx_hold n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
                end
                if (f == 1 && i == 39) bus.tx_left = 16'hFFFF;
            end
            if (f == 1) begin
                compared++;
                if (bus.rx_left !== 16'h1234) begin
                    mismatched++;
                    $display("FAIL tx_hold_current got %h want 1234", bus.rx_left);
                end
            end
            if (f == 2) begin
                compared++;
                if (bus.rx_left !== 16'hFFFF) begin
                    mismatched++;
                    $display("FAIL tx_hold_next got %h want ffff", bus.rx_left);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        int early = 0;
        loop = 1'b1;
        bus.tx_left = W'($urandom) | 16'h0101;
        bus.tx_right = W'($urandom) | 16'h0101;
        for (int i = 0; i < 160; i++) step();
        #2;
        rst = 1'b1;
        #1;
        ov = {bus.mclk_o, bus.bclk_o, bus.lrclk_o, bus.sdata_o, bus.sample_tick, bus.rx_valid};
        compared++;
        if ({ov, bus.rx_left, bus.rx_right} !== '0) begin
            mismatched++;
            $display("FAIL async_reset got %b %h %h want all zero", ov, bus.rx_left, bus.rx_right);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < FR; i++) begin
            step();
            compared++;
            if ({ov, bus.rx_left, bus.rx_right} !== {ev, rxe_l, rxe_r}) begin
                mismatched++;
                $display("FAIL post_reset n=%0d got %b %h %h want %b %h %h", n, ov, bus.rx_left, bus.rx_right, ev, rxe_l, rxe_r);
            end
            if (bus.rx_valid && n < FR) early++;
        end
        compared++;
        if (early !== 0) begin
            mismatched++;
            $display("FAIL early_rx_valid got %0d want 0", early);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clocks();
        test_pattern();
        test_loopback();
        test_const_ones();
        test_tx_hold();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/i2s_driver.md
I2S_DRIVER -- requirements
Module: i2s_driver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: audio sample width; legal range 1..31.
REQ-002 SHALL have parameter BCLK_HALF, default 4: clk cycles per bclk half-period; legal range >= 2.
REQ-003 clk  input  1  system clock; sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mclk_o  output  1  codec master clock, clk/2.
REQ-006 bclk_o  output  1  bit clock, clk/(2*BCLK_HALF).
REQ-007 lrclk_o  output  1  word select; 0 = left slot, 1 = right slot.
REQ-008 sdata_o  output  1  serial data to DAC.
REQ-009 sdata_i  input  1  serial data from ADC.
REQ-010 tx_left, tx_right  input  DATA_WIDTH each  samples to transmit, two's complement.
REQ-011 sample_tick  output  1  one-clk pulse at each frame boundary; tx inputs are latched on this cycle.
REQ-012 rx_left, rx_right  output  DATA_WIDTH each  last received samples, held between ticks.
REQ-013 rx_valid  output  1  one-clk pulse when rx_left/rx_right update.

Function
REQ-014 Free-running div_cnt SHALL count 0..2*BCLK_HALF-1 and wrap; bclk_o SHALL be high for div_cnt in [BCLK_HALF, 2*BCLK_HALF-1].
REQ-015 bit_cnt (6 bits) SHALL increment on each bclk falling edge (div_cnt wrap) and wrap 63->0; frame = 64 bclk = 128*BCLK_HALF clk.
REQ-016 lrclk_o SHALL equal bit_cnt[5], changing on bclk falling edges only.
REQ-017 Each 32-bit slot: bit 0 = I2S one-bit delay (sdata_o 0), bits 1..DATA_WIDTH = sample MSB first, remaining bits 0.
REQ-018 sdata_o SHALL change only on bclk falling edges; sdata_i SHALL be sampled on the clk where bclk_o rises.
REQ-019 On bit_cnt wrap 63->0: tx_left/tx_right latched into shift registers, sample_tick = 1 for that clk; later tx input changes SHALL NOT affect the frame in progress.
REQ-020 On the same cycle, rx_left/rx_right SHALL load the samples captured during the ending frame and rx_valid = 1; tick and rx_valid coincide.
REQ-021 Loopback latency: a sample latched on tick N SHALL appear on rx outputs at tick N+1.
REQ-022 mclk_o SHALL toggle every clk, independent of other counters.
REQ-023 All outputs SHALL be registered; no combinational input-to-output paths.

Reset
REQ-024 While rst = 1: all outputs 0, div_cnt = 0, bit_cnt = 0, shift registers 0, effective immediately (asynchronous).
REQ-025 After release, first frame SHALL transmit zeros; first sample_tick/rx_valid SHALL occur 128*BCLK_HALF clk after release; reset mid-frame SHALL discard the partial frame, no rx_valid for it.

Structure
REQ-026 Package i2s_pkg SHALL hold FRAME_BITS = 64, SLOT_BITS = 32 and a sample-pair struct type.
REQ-027 Sub-module i2s_clkgen SHALL contain div_cnt/bit_cnt and produce bclk/lrclk/mclk plus fall/rise strobes; shifting stays in i2s_driver.

Verification (DATA_WIDTH = 16, BCLK_HALF = 4)
REQ-028 Release rst at cycle 0 -> bclk_o first rises at cycle 4, period 8 clk; lrclk_o low 256 clk, high 256 clk; first sample_tick at cycle 512.
REQ-029 tx_left = 16'hA5C3, tx_right = 16'h0001 held -> after tick, sdata_o left slot bits 1..16 = A5C3 MSB first, right slot bit 16 = 1, all other bits 0.
REQ-030 sdata_o looped to sdata_i, tx_left = 16'h8000, tx_right = 16'h7FFF -> at next tick rx_left = 16'h8000, rx_right = 16'h7FFF, rx_valid one clk.
REQ-031 sdata_i = 1 constant -> rx_left = rx_right = 16'hFFFF on every rx_valid.
REQ-032 tx_left changed 16'h1234 -> 16'hFFFF at bit_cnt = 5 -> current frame carries 16'h1234; next frame carries 16'hFFFF.
REQ-033 rst asserted at bit_cnt = 20 for 3 clk -> all outputs 0 same cycle; after release no rx_valid before 512 clk; next frame transmits zeros.
